md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource of the pipelined MIPS CPU.
- Sits in the E stage. It accepts mult/multu/div/divu/mthi/mtlo starts and models fixed multi-cycle latency with a busy counter.
- Commits results to HI/LO when the count finishes.
- Raises a stall request so the D stage holds any HI/LO-using instruction while the unit is occupied.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- md_start  in  1  E-stage instruction is a HI/LO op this cycle; sampled at the edge.
- md_op  in  3  operation code from package; ignored when md_start=0.
- md_a  in  32  rs operand (E-stage forwarded value).
- md_b  in  32  rt operand (E-stage forwarded value).
- md_use_d  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  multi-cycle operation in flight.
- stall  out  1  stall request to the hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset: when reset_n=0 at an edge, hi=0, lo=0, counter=0, pending regs=0, busy=0.
  - Reset overrides md_start in the same edge.
  - Reset mid-operation aborts it; nothing is committed.
- State: counter (width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1)), plus pending_hi/pending_lo, plus pending_wr (1 = commit allowed).
- busy = (counter != 0). This is combinational from the counter.
- stall = md_use_d & (busy | md_start). This is combinational.
  - The hi/lo values seen by mfhi/mflo are therefore always committed values.
- Accepted start: md_start=1, busy=0, reset_n=1.
  - MULT: pending = signed(md_a)*signed(md_b), 64-bit. pending_hi = [63:32], pending_lo = [31:0]. pending_wr=1. counter ← MULT_CYCLES.
  - MULTU: same as MULT, with unsigned product.
  - DIV: pending_lo = signed quotient, truncated toward zero. pending_hi = remainder, which takes the sign of the dividend.
    - Special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
    - counter ← DIV_CYCLES.
  - DIVU: unsigned quotient and remainder; counter ← DIV_CYCLES.
  - Divide by zero (div or divu, md_b=0): counter still loads DIV_CYCLES and busy still asserts. pending_wr=0, so hi/lo stay unchanged at commit.
  - MTHI: hi ← md_a at this edge. No busy, counter unchanged.
  - MTLO: lo ← md_a at this edge. No busy, counter unchanged.
  - MD_NONE: no effect.
- Counting: on each edge with counter>0, counter decrements.
  - On the edge where counter==1: if pending_wr, then hi←pending_hi and lo←pending_lo. counter→0.
  - Timing: start sampled at edge t0; busy=1 during the N cycles after t0; new hi/lo are visible in the same cycle busy falls (after edge t0+N).
- Start while busy: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not happen via stall.
  - The bench flags it as a protocol violation but the RTL must stay consistent.
- Operands are captured at the start edge. Later changes to md_a/md_b have no effect.
- Back-to-back: a new start is accepted in the first cycle with busy=0, i.e. at edge t0+N+1 at the earliest.

Decomposition:
- Shared package md_pkg holds:
  - MD_OP width (3) and codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Default latency constants.
- One natural sub-module: md_arith.
  - Combinational; computes {hi,lo} and a div-by-zero flag from op, a and b.
  - md_unit_ctrl keeps only counter, pending regs, HI/LO and stall logic.

Test Plan:
- MULT a=0xFFFFFFFD, b=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. stall=1 while md_use_d=1 during busy.
- MULTU a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Also check 0x80000000 DIV 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- MTHI a=0x12345678, then DIVU a=7, b=0 → hi=0x12345678 immediately after the MTHI edge. busy high 10 cycles for the DIVU. hi/lo unchanged afterwards.
- MULT started, reset_n=0 at cycle 3 of busy → busy=0, hi=lo=0 next cycle; no later commit.
- Start while busy (MTLO mid-DIV) → ignored, lo gets the div result only. md_use_d=1 with md_start=1 and busy=0 → stall=1 that cycle.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes and
// default latencies.
package md_pkg;

   localparam int MD_OP_W = 3;

   typedef enum logic [MD_OP_W-1:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the md unit.
interface md_unit_ctrl_if;
   import md_pkg::*;

   logic        md_start;
   md_op_e      md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_use_d;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output md_start, md_op, md_a, md_b, md_use_d,
      input  busy, stall, hi, lo
   );

   modport slave (
      input  md_start, md_op, md_a, md_b, md_use_d,
      output busy, stall, hi, lo
   );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces the {hi,lo} pair for an
// operation and flags division by zero.
module md_arith
   import md_pkg::*;
(
   input  md_op_e      op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div0_o
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] sa;
   logic signed [31:0] sb;

   always_comb begin
      // NOTE: every output and temporary gets a default first so no path through the case infers a latch.
      hi_o   = '0;
      lo_o   = '0;
      div0_o = 1'b0;
      prod_s = '0;
      prod_u = '0;
      sa     = $signed(a_i);
      sb     = $signed(b_i);
      case (op_i)
         MD_MULT: begin
            prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
            hi_o   = prod_s[63:32];
            lo_o   = prod_s[31:0];
         end
         MD_MULTU: begin
            prod_u = {32'd0, a_i} * {32'd0, b_i};
            hi_o   = prod_u[63:32];
            lo_o   = prod_u[31:0];
         end
         MD_DIV: begin
            if (b_i == 32'd0) begin
               div0_o = 1'b1;
            end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
               // The only signed overflow: the quotient wraps back to the dividend.
               lo_o = a_i;
               hi_o = '0;
            end else begin
               lo_o = sa / sb;
               hi_o = sa % sb;
            end
         end
         MD_DIVU: begin
            if (b_i == 32'd0) begin
               div0_o = 1'b1;
            end else begin
               lo_o = a_i / b_i;
               hi_o = a_i % b_i;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit_ctrl.sv
// HI/LO sequencing controller: holds the result of a mult/div in pending
// registers for a fixed latency, then commits it, and requests D-stage stalls.
module md_unit_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input logic           clk,
   input logic           reset_n,
   md_unit_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
   typedef logic [CNT_W-1:0] cnt_t;

   cnt_t        cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic [31:0] arith_hi;
   logic [31:0] arith_lo;
   logic        arith_div0;
   logic        busy;

   md_arith u_arith (
      .op_i   (bus.md_op),
      .a_i    (bus.md_a),
      .b_i    (bus.md_b),
      .hi_o   (arith_hi),
      .lo_o   (arith_lo),
      .div0_o (arith_div0)
   );

   assign busy      = (cnt_q != '0);
   assign bus.busy  = busy;
   assign bus.stall = bus.md_use_d & (busy | bus.md_start);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      if (busy) begin
         // Any start arriving while busy is dropped, MTHI/MTLO included.
         cnt_d = cnt_q - cnt_t'(1);
         if (cnt_q == cnt_t'(1) && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (bus.md_start) begin
         case (bus.md_op)
            MD_MULT, MD_MULTU: begin
               pend_hi_d = arith_hi;
               pend_lo_d = arith_lo;
               pend_wr_d = 1'b1;
               cnt_d     = cnt_t'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
               pend_hi_d = arith_hi;
               pend_lo_d = arith_lo;
               pend_wr_d = ~arith_div0;
               cnt_d     = cnt_t'(DIV_CYCLES);
            end
            MD_MTHI: hi_d = bus.md_a;
            MD_MTLO: lo_d = bus.md_a;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates are non-blocking; the reset is synchronous and clears pending regs too, so an aborted op can never commit.
      if (!reset_n) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases plus random traffic
// compared against a transaction-level HI/LO model.
module tb_md_unit_ctrl;
   import md_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   md_unit_ctrl_if bus ();

   md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Reference model: architectural HI/LO plus the edge index at which the
   // in-flight op finishes and the value it will deliver.
   int          n_total = 0;
   int          n_bad   = 0;
   int          n_proto = 0;
   int          cyc     = 0;
   int          busy_until = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   bit          p_wr = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   // Compute the op result from plain 64-bit arithmetic on magnitudes.
   task automatic model_start(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, ma, mb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MD_MULT: begin
            v = sa * sb;
            p_hi = v[63:32]; p_lo = v[31:0]; p_wr = 1'b1;
            busy_until = cyc + MC;
         end
         MD_MULTU: begin
            v = ua * ub;
            p_hi = v[63:32]; p_lo = v[31:0]; p_wr = 1'b1;
            busy_until = cyc + MC;
         end
         MD_DIV: begin
            p_wr = (b != 0);
            if (b != 0) begin
               ma = (sa < 0) ? -sa : sa;
               mb = (sb < 0) ? -sb : sb;
               q = ma / mb;
               r = ma % mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               if (sa < 0) r = -r;
               v = q; p_lo = v[31:0];
               v = r; p_hi = v[31:0];
            end
            busy_until = cyc + DC;
         end
         MD_DIVU: begin
            p_wr = (b != 0);
            if (b != 0) begin
               v = ua / ub; p_lo = v[31:0];
               v = ua % ub; p_hi = v[31:0];
            end
            busy_until = cyc + DC;
         end
         MD_MTHI: m_hi = a;
         MD_MTLO: m_lo = a;
         default: ;
      endcase
   endtask

   // One clock: drive inputs, check combinational outputs, clock, update
   // the model, check registered outputs.
   task automatic step(input logic st, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d, input logic rn);
      bit exp_busy;
      bus.md_start = st;
      bus.md_op    = op;
      bus.md_a     = a;
      bus.md_b     = b;
      bus.md_use_d = use_d;
      reset_n      = rn;
      #1;
      exp_busy = (cyc < busy_until);
      if (cyc > 0) begin
         check("busy_pre", {63'd0, bus.busy}, {63'd0, exp_busy});
         check("stall", {63'd0, bus.stall}, {63'd0, use_d & (exp_busy | st)});
      end
      @(posedge clk);
      cyc++;
      if (!rn) begin
         m_hi = '0; m_lo = '0; p_wr = 1'b0;
         busy_until = cyc;
      end else if (exp_busy) begin
         if (st) n_proto++;
         if (cyc == busy_until && p_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (st) begin
         model_start(op, a, b);
      end
      #1;
      check("busy", {63'd0, bus.busy}, {63'd0, (cyc < busy_until)});
      check("hi", {32'd0, bus.hi}, {32'd0, m_hi});
      check("lo", {32'd0, bus.lo}, {32'd0, m_lo});
   endtask

   task automatic idle(input int n, input logic use_d);
      for (int i = 0; i < n; i++) step(1'b0, MD_NONE, pick(), pick(), use_d, 1'b1);
   endtask

   initial begin
      step(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
      step(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
      check("rst_hi", {32'd0, bus.hi}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);

      // MULT -3*5 with a D-stage HI/LO user waiting; stall on the start cycle too
      step(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
      idle(MC, 1'b1);
      check("mult_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
      check("mult_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFF1);

      step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
      idle(MC, 1'b0);
      check("multu_hi", {32'd0, bus.hi}, 64'h1);
      check("multu_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFE);

      step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      idle(DC, 1'b0);
      check("divovf_lo", {32'd0, bus.lo}, 64'h0000_0000_8000_0000);
      check("divovf_hi", {32'd0, bus.hi}, 64'h0);

      step(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
      idle(DC, 1'b1);
      check("div_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFD);
      check("div_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);

      step(1'b1, MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b1);
      idle(DC, 1'b0);
      check("divu_lo", {32'd0, bus.lo}, 64'd3);
      check("divu_hi", {32'd0, bus.hi}, 64'd1);

      // MTHI is immediate; divide-by-zero is busy but never commits
      step(1'b1, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      check("mthi", {32'd0, bus.hi}, 64'h1234_5678);
      step(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b1);
      idle(DC + 2, 1'b0);
      check("div0_hi", {32'd0, bus.hi}, 64'h1234_5678);
      check("div0_lo", {32'd0, bus.lo}, 64'd3);

      // Reset on the third busy cycle aborts the MULT
      step(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0, 1'b1);
      idle(2, 1'b0);
      step(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_hi", {32'd0, bus.hi}, 64'd0);
      idle(MC + 2, 1'b0);
      check("abort_lo", {32'd0, bus.lo}, 64'd0);

      // MTLO issued mid-DIV is dropped
      step(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
      idle(3, 1'b0);
      step(1'b1, MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
      idle(DC, 1'b0);
      check("mtlo_drop_lo", {32'd0, bus.lo}, 64'd14);
      check("mtlo_drop_hi", {32'd0, bus.hi}, 64'd2);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 2) == 0, md_op_e'($urandom_range(0, 6)), pick(), pick(),
              1'($urandom_range(0, 1)), $urandom_range(0, 79) != 0);
      end

      if (n_proto > 0) $display("note: %0d starts were issued while busy", n_proto);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
